hdlverifier_capture_trigger_controller: RTL

Capture controller that consumes the registered `trigger` pulse from the capture comparator and writes a pre-/post-trigger window of samples into the capture buffer RAM. The buffer is used as a circular buffer. The block sits between the comparator and the dual-port capture RAM in the data-capture subsystem. It reports where the captured window starts so the host readout path can unroll it.

---
 rtl/hdlverifier_capture_trigger_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hdlverifier_capture_trigger_controller.sv
// Pre/post-trigger capture controller: streams delayed samples into a circular
// capture RAM and reports the address of the oldest sample in the window.
module hdlverifier_capture_trigger_controller #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  trigger,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] trigger_position,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic                  armed,
    output logic                  triggered,
    output logic                  capture_done,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [2:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] dataD1_q,    dataD1_d;
    logic [ADDR_WIDTH-1:0] wrPtr_q,     wrPtr_d;
    logic [ADDR_WIDTH-1:0] preCount_q,  preCount_d;
    logic [ADDR_WIDTH-1:0] fillLeft_q,  fillLeft_d;
    logic [ADDR_WIDTH-1:0] postLeft_q,  postLeft_d;
    logic [ADDR_WIDTH-1:0] startAddr_q, startAddr_d;
    logic                  wrEn_q,      wrEn_d;
    logic [ADDR_WIDTH-1:0] wrAddr_q,    wrAddr_d;
    logic [DATA_WIDTH-1:0] wrData_q,    wrData_d;

    // Every state except IDLE/DONE writes the one-cycle-delayed sample, so that
    // the sample and its registered trigger flag are handled together.
    always_comb begin
        state_d     = state_q;
        dataD1_d    = dataD1_q;
        wrPtr_d     = wrPtr_q;
        preCount_d  = preCount_q;
        fillLeft_d  = fillLeft_q;
        postLeft_d  = postLeft_q;
        startAddr_d = startAddr_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;

        if (clk_enable) begin
            dataD1_d = data_in;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        preCount_d = trigger_position;
                        fillLeft_d = trigger_position;
                        wrPtr_d    = '0;
                        state_d    = (trigger_position == '0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    wrEn_d     = 1'b1;
                    wrAddr_d   = wrPtr_q;
                    wrData_d   = dataD1_q;
                    wrPtr_d    = wrPtr_q + ONE;
                    fillLeft_d = fillLeft_q - ONE;
                    if (fillLeft_q == ONE) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wrEn_d   = 1'b1;
                    wrAddr_d = wrPtr_q;
                    wrData_d = dataD1_q;
                    wrPtr_d  = wrPtr_q + ONE;
                    if (trigger) begin
                        // D-1-P post samples is the bitwise complement of P
                        startAddr_d = wrPtr_q - preCount_q;
                        postLeft_d  = ~preCount_q;
                        state_d     = (preCount_q == '1) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wrEn_d     = 1'b1;
                    wrAddr_d   = wrPtr_q;
                    wrData_d   = dataD1_q;
                    wrPtr_d    = wrPtr_q + ONE;
                    postLeft_d = postLeft_q - ONE;
                    if (postLeft_q == ONE) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dataD1_q    <= '0;
            wrPtr_q     <= '0;
            preCount_q  <= '0;
            fillLeft_q  <= '0;
            postLeft_q  <= '0;
            startAddr_q <= '0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
        end else begin
            state_q     <= state_d;
            dataD1_q    <= dataD1_d;
            wrPtr_q     <= wrPtr_d;
            preCount_q  <= preCount_d;
            fillLeft_q  <= fillLeft_d;
            postLeft_q  <= postLeft_d;
            startAddr_q <= startAddr_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
        end
    end

    assign buf_wr_en    = wrEn_q;
    assign buf_wr_addr  = wrAddr_q;
    assign buf_wr_data  = wrData_q;
    assign armed        = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
    assign triggered    = (state_q == S_POST) || (state_q == S_DONE);
    assign capture_done = (state_q == S_DONE);
    assign start_addr   = startAddr_q;

endmodule
